// File: rtl/gtfmac_wrapper_axi_cfg_sequencer.sv
// gtfmac_wrapper_axi_cfg_sequencer: AXI4-Lite write master that loads the five GTFMAC control registers
module gtfmac_wrapper_axi_cfg_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit AUTO_START = 1'b1
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_areset,
  input  logic        start,
  input  logic        cfg_rx_data_rate,
  input  logic        cfg_tx_data_rate,
  input  logic        cfg_tx_fcs_ins_enable,
  input  logic        cfg_tx_ignore_fcs,
  input  logic        cfg_rx_ignore_fcs,
  input  logic [7:0]  cfg_rx_min_packet_len,
  input  logic [15:0] cfg_rx_max_packet_len,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_index,
  output logic [1:0]  err_resp
);
  typedef enum logic [2:0] {IDLE, ADDR, RESP, DONE, ERROR} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t state;
  logic auto_pend, rx_rate, tx_rate, fcs_ins, tx_ign, rx_ign;
  logic [7:0] min_len;
  logic [15:0] max_len;
  logic [2:0] idx, nidx;
  logic [TW-1:0] tcnt;
  logic [31:0] next_word;
  logic timeout, fail, b_ok;
  logic [1:0] fail_resp;
  assign m_axi_wstrb = 4'hF;
  always_comb begin
    nidx = idx + 3'd1;
    next_word = nidx == 3'd1 ? {29'b0, tx_ign, fcs_ins, 1'b0} :
                nidx == 3'd2 ? {29'b0, rx_ign, 2'b0} :
                nidx == 3'd3 ? {24'b0, min_len} : {16'b0, max_len};
    timeout = tcnt == TW'(TIMEOUT_CYCLES - 1);
    b_ok = state == RESP && m_axi_bvalid && m_axi_bresp == 2'b00;
    fail = (state == RESP && m_axi_bvalid && m_axi_bresp != 2'b00) ||
           (timeout && (state == ADDR || (state == RESP && !m_axi_bvalid)));
    fail_resp = (state == RESP && m_axi_bvalid) ? m_axi_bresp : 2'b11;
  end
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state <= IDLE;
      auto_pend <= AUTO_START;
      {rx_rate, tx_rate, fcs_ins, tx_ign, rx_ign} <= '0;
      min_len <= '0;
      max_len <= '0;
      idx <= '0;
      tcnt <= '0;
      m_axi_awaddr <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata <= '0;
      m_axi_wvalid <= 1'b0;
      m_axi_bready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      err_index <= '0;
      err_resp <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: if (start || auto_pend) begin
          auto_pend <= 1'b0;
          {rx_rate, tx_rate, fcs_ins, tx_ign, rx_ign} <= {cfg_rx_data_rate, cfg_tx_data_rate,
            cfg_tx_fcs_ins_enable, cfg_tx_ignore_fcs, cfg_rx_ignore_fcs};
          min_len <= cfg_rx_min_packet_len;
          max_len <= cfg_rx_max_packet_len;
          idx <= '0;
          tcnt <= '0;
          m_axi_awaddr <= BASE_ADDR;
          m_axi_awvalid <= 1'b1;
          m_axi_wdata <= {30'b0, cfg_tx_data_rate, cfg_rx_data_rate};
          m_axi_wvalid <= 1'b1;
          busy <= 1'b1;
          done <= 1'b0;
          error <= 1'b0;
          err_index <= '0;
          err_resp <= '0;
          state <= ADDR;
        end
        ADDR: begin
          tcnt <= tcnt + TW'(1);
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready) m_axi_wvalid <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          tcnt <= tcnt + TW'(1);
          if (b_ok) begin
            idx <= nidx;
            m_axi_bready <= 1'b0;
            if (idx == 3'd4) begin
              busy <= 1'b0;
              done <= 1'b1;
              state <= DONE;
            end else begin
              tcnt <= '0;
              m_axi_awaddr <= BASE_ADDR | {27'b0, nidx, 2'b00};
              m_axi_awvalid <= 1'b1;
              m_axi_wdata <= next_word;
              m_axi_wvalid <= 1'b1;
              state <= ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // a bad response or a timeout abandons the write outright, valids included
      if (fail) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid <= 1'b0;
        m_axi_bready <= 1'b0;
        busy <= 1'b0;
        error <= 1'b1;
        err_index <= idx;
        err_resp <= fail_resp;
        state <= ERROR;
      end
    end
  end
endmodule

// File: tb/tb_gtfmac_wrapper_axi_cfg_sequencer.sv
// tb_gtfmac_wrapper_axi_cfg_sequencer: randomized scenarios against a register-level model and an AXI slave model
module tb_gtfmac_wrapper_axi_cfg_sequencer;
  logic clk = 1'b0, areset = 1'b1, start = 1'b0;
  logic rx_rate = 0, tx_rate = 0, fcs_ins = 0, tx_ign = 0, rx_ign = 0;
  logic [7:0] min_len = 0;
  logic [15:0] max_len = 0;
  logic [31:0] awaddr, wdata;
  logic [3:0] wstrb;
  logic awvalid, wvalid, bready, busy, done, error;
  logic awready = 0, wready = 0, bvalid = 0;
  logic [1:0] bresp = 0, err_resp;
  logic [2:0] err_index;
  int n_tests = 0, n_fail = 0;
  int aw_delay = 1, w_delay = 1, aw_wait = 0, w_wait = 0;
  logic b_never = 0, aw_got = 0, w_got = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF, last_aw = 0;
  logic [1:0] err_code = 2'b10;
  logic [31:0] aw_q[$], w_q[$];
  logic [31:0] exp_w[5];

  always #5 clk = ~clk;

  gtfmac_wrapper_axi_cfg_sequencer #(.BASE_ADDR(32'h0), .TIMEOUT_CYCLES(16), .AUTO_START(1'b1)) dut (
    .s_axi_aclk(clk), .s_axi_areset(areset), .start(start),
    .cfg_rx_data_rate(rx_rate), .cfg_tx_data_rate(tx_rate), .cfg_tx_fcs_ins_enable(fcs_ins),
    .cfg_tx_ignore_fcs(tx_ign), .cfg_rx_ignore_fcs(rx_ign),
    .cfg_rx_min_packet_len(min_len), .cfg_rx_max_packet_len(max_len),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .busy(busy), .done(done), .error(error), .err_index(err_index), .err_resp(err_resp));

  always @(posedge clk) begin
    if (areset) begin
      aw_got = 0;
      w_got = 0;
    end else begin
      if (awvalid && awready) begin aw_q.push_back(awaddr); last_aw = awaddr; aw_got = 1; end
      if (wvalid && wready) begin w_q.push_back(wdata); w_got = 1; end
      if (bvalid && bready) begin aw_got = 0; w_got = 0; end
    end
  end

  always @(negedge clk) begin
    if (awvalid) begin awready = aw_wait >= aw_delay; aw_wait++; end
    else begin awready = 0; aw_wait = 0; end
    if (wvalid) begin wready = w_wait >= w_delay; w_wait++; end
    else begin wready = 0; w_wait = 0; end
    if (aw_got && w_got && !b_never) begin
      bvalid = 1;
      bresp = (last_aw == err_addr) ? err_code : 2'b00;
    end else begin
      bvalid = 0;
      bresp = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  task automatic build_model();
    exp_w[0] = 32'(rx_rate) + 32'(tx_rate) * 32'd2;
    exp_w[1] = 32'(fcs_ins) * 32'd2 + 32'(tx_ign) * 32'd4;
    exp_w[2] = 32'(rx_ign) * 32'd4;
    exp_w[3] = 32'(min_len);
    exp_w[4] = 32'(max_len);
  endtask

  task automatic rand_cfg();
    {rx_rate, tx_rate, fcs_ins, tx_ign, rx_ign} = 5'($urandom);
    min_len = 8'($urandom);
    max_len = 16'($urandom);
    build_model();
  endtask

  function automatic bit seq_matches(input int n);
    if (aw_q.size() != n || w_q.size() != n) return 0;
    for (int i = 0; i < n; i++)
      if (aw_q[i] !== 32'(i * 4) || w_q[i] !== exp_w[i]) return 0;
    return 1;
  endfunction

  task automatic pulse_start();
    aw_q.delete();
    w_q.delete();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_end(output int cyc);
    cyc = 0;
    while (!(done || error) && cyc < 200) begin @(negedge clk); cyc++; end
  endtask

  task automatic do_reset();
    int c;
    areset = 1;
    @(negedge clk);
    @(negedge clk);
    b_never = 0; aw_delay = 1; w_delay = 1; err_addr = 32'hFFFF_FFFF;
    rand_cfg();
    aw_q.delete();
    w_q.delete();
    areset = 0;
    @(negedge clk);
    wait_end(c);
    n_tests++;
    if (done !== 1'b1 || !seq_matches(5)) begin
      n_fail++;
      $display("FAIL reset_rerun: done=%b writes=%0d, required done=1 writes=5", done, w_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({awvalid, wvalid, bready, busy, done, error} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b, required 000000", {awvalid, wvalid, bready, busy, done, error});
    end
    n_tests++;
    if ({awaddr, wdata, err_index, err_resp} !== 69'b0) begin
      n_fail++;
      $display("FAIL reset_data: awaddr=%h wdata=%h idx=%0d resp=%0d, required all 0", awaddr, wdata, err_index, err_resp);
    end
    n_tests++;
    if (wstrb !== 4'hF) begin n_fail++; $display("FAIL reset_wstrb: got %h, required f", wstrb); end
  endtask

  task automatic test_auto_start();
    int c;
    {rx_rate, tx_rate, fcs_ins, tx_ign, rx_ign} = 5'b00100;
    min_len = 8'd64;
    max_len = 16'd9600;
    build_model();
    aw_q.delete();
    w_q.delete();
    areset = 0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL auto_busy: got %b, required 1", busy); end
    wait_end(c);
    n_tests++;
    if (done !== 1'b1 || error !== 1'b0 || c != 15) begin
      n_fail++;
      $display("FAIL auto_latency: done=%b error=%b cycles=%0d, required 1 0 15", done, error, c);
    end
    n_tests++;
    if (!seq_matches(5) || w_q[1] !== 32'd2 || w_q[3] !== 32'd64 || w_q[4] !== 32'd9600) begin
      n_fail++;
      $display("FAIL auto_writes: count=%0d, required 5 writes data 0,2,0,64,9600", w_q.size());
    end
  endtask

  task automatic test_aw_delay();
    int c;
    bit w_first = 0, unstable = 0;
    logic [31:0] a0;
    aw_delay = 3;
    w_delay = 0;
    rand_cfg();
    pulse_start();
    a0 = awaddr;
    c = 0;
    while (awvalid && c < 20) begin
      if (!wvalid) w_first = 1;
      if (awaddr !== a0) unstable = 1;
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (!w_first || unstable) begin
      n_fail++;
      $display("FAIL aw_delay_hs: wvalid_dropped_first=%b awaddr_unstable=%b, required 1 0", w_first, unstable);
    end
    wait_end(c);
    n_tests++;
    if (done !== 1'b1 || !seq_matches(5)) begin
      n_fail++;
      $display("FAIL aw_delay_seq: done=%b writes=%0d, required done=1 and 5 modelled writes", done, w_q.size());
    end
    aw_delay = 1;
    w_delay = 1;
  endtask

  task automatic test_slverr();
    int c;
    err_addr = 32'h0000_000C;
    err_code = 2'b10;
    rand_cfg();
    pulse_start();
    wait_end(c);
    repeat (4) @(negedge clk);
    n_tests++;
    if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || err_index !== 3'd3 || err_resp !== 2'b10) begin
      n_fail++;
      $display("FAIL slverr_status: err=%b done=%b busy=%b idx=%0d resp=%b, required 1 0 0 3 10",
               error, done, busy, err_index, err_resp);
    end
    n_tests++;
    if (!seq_matches(4)) begin
      n_fail++;
      $display("FAIL slverr_writes: got %0d writes, required 4 (none to 0x010)", aw_q.size());
    end
    err_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_timeout();
    int c;
    for (int v = 0; v < 2; v++) begin
      b_never = (v == 0);
      aw_delay = (v == 0) ? 1 : 1000;
      rand_cfg();
      pulse_start();
      c = 0;
      while (!error && c < 100) begin @(negedge clk); c++; end
      n_tests++;
      if (c != 16 || err_resp !== 2'b11 || err_index !== 3'd0) begin
        n_fail++;
        $display("FAIL timeout_%0d: cycles=%0d resp=%b idx=%0d, required 16 11 0", v, c, err_resp, err_index);
      end
      n_tests++;
      if ({awvalid, wvalid, bready, busy, done} !== 5'b0) begin
        n_fail++;
        $display("FAIL timeout_valids_%0d: got %b, required 00000", v, {awvalid, wvalid, bready, busy, done});
      end
      do_reset();
    end
  endtask

  task automatic test_start_ignored();
    int c;
    rand_cfg();
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1;
    max_len = ~max_len;
    @(negedge clk);
    start = 0;
    wait_end(c);
    repeat (5) @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || !seq_matches(5)) begin
      n_fail++;
      $display("FAIL start_ignored: done=%b writes=%0d last=%h, required done=1 5 writes last=%h",
               done, w_q.size(), (w_q.size() > 0) ? w_q[w_q.size() - 1] : 32'h0, exp_w[4]);
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    rand_cfg();
    pulse_start();
    while (!(aw_q.size() == 3 && bready) && c < 100) begin @(negedge clk); c++; end
    n_tests++;
    if (!(aw_q.size() == 3 && bready)) begin n_fail++; $display("FAIL reset_mid_reach: writes=%0d bready=%b, required 3 1", aw_q.size(), bready); end
    areset = 1;
    @(negedge clk);
    n_tests++;
    if ({awvalid, wvalid, bready, busy, done, error, awaddr, wdata} !== 70'b0 || wstrb !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_mid_out: ctl=%b awaddr=%h wdata=%h wstrb=%h, required zeros and f",
               {awvalid, wvalid, bready, busy, done, error}, awaddr, wdata, wstrb);
    end
    rand_cfg();
    aw_q.delete();
    w_q.delete();
    areset = 0;
    @(negedge clk);
    wait_end(c);
    n_tests++;
    if (done !== 1'b1 || !seq_matches(5)) begin
      n_fail++;
      $display("FAIL reset_mid_rerun: done=%b writes=%0d first=%h, required 1 5 00000000",
               done, aw_q.size(), (aw_q.size() > 0) ? aw_q[0] : 32'hX);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    for (int k = 0; k < 3; k++) begin
      rand_cfg();
      pulse_start();
      wait_end(c);
      n_tests++;
      if (done !== 1'b1 || error !== 1'b0 || !seq_matches(5)) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: done=%b error=%b writes=%0d, required 1 0 5", k, done, error, w_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_aw_delay();
    test_slverr();
    test_back_to_back();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
